// File: rtl/mmm_inv_arbiter_if.sv
// Requester and engine bus of mmm_inv_arbiter. The slave modport is the arbiter side.
interface mmm_inv_arbiter_if #(
  parameter int WIDTH = 260,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]       i_req;
  logic [NREQ*WIDTH-1:0] i_n;
  logic [NREQ*WIDTH-1:0] i_r;
  logic [NREQ-1:0]       o_gnt;
  logic [WIDTH-1:0]      o_res;
  logic [NREQ-1:0]       o_res_valid;
  logic                  o_err;
  logic                  o_busy;
  logic [WIDTH-1:0]      o_eng_n;
  logic [WIDTH-1:0]      o_eng_r;
  logic                  o_eng_valid;
  logic [WIDTH-1:0]      i_eng_res;
  logic                  i_eng_valid;

  modport slave (
    input  i_req, i_n, i_r, i_eng_res, i_eng_valid,
    output o_gnt, o_res, o_res_valid, o_err, o_busy, o_eng_n, o_eng_r, o_eng_valid
  );

  modport master (
    output i_req, i_n, i_r, i_eng_res, i_eng_valid,
    input  o_gnt, o_res, o_res_valid, o_err, o_busy, o_eng_n, o_eng_r, o_eng_valid
  );
endinterface

// File: rtl/mmm_inv_arbiter.sv
// Round-robin arbiter sharing one mmm_mod_inv engine among NREQ requesters.
// Optional WAIT watchdog enabled by defining MMM_INV_ARB_TMO_EN.
module mmm_inv_arbiter #(
  parameter int WIDTH   = 260,
  parameter int NREQ    = 4,
  parameter int TMO_CYC = 1024
) (
  input  logic i_clk,
  input  logic i_rstn,
  mmm_inv_arbiter_if.slave bus
);
  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     own_q, own_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   vld_q, vld_d;
  logic              eng_v_q, eng_v_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [WIDTH-1:0]  n_q, n_d;
  logic [WIDTH-1:0]  r_q, r_d;

  logic              found;
  logic [PW-1:0]     pick;

`ifdef MMM_INV_ARB_TMO_EN
  localparam int CW = $clog2(TMO_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO_CYC;
`endif

  // First requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      int unsigned idx;
      idx = (32'(ptr_q) + i) % NREQ;
      if (!found && bus.i_req[idx]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    gnt_d   = '0;
    vld_d   = '0;
    eng_v_d = 1'b0;
    err_d   = 1'b0;
    res_d   = res_q;
    n_d     = n_q;
    r_d     = r_q;
`ifdef MMM_INV_ARB_TMO_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d     = S_ISSUE;
          own_d       = pick;
          gnt_d[pick] = 1'b1;
          eng_v_d     = 1'b1;
          n_d         = bus.i_n[32'(pick)*WIDTH +: WIDTH];
          r_d         = bus.i_r[32'(pick)*WIDTH +: WIDTH];
          ptr_d       = (pick == PW'(NREQ - 1)) ? '0 : pick + PW'(1);
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef MMM_INV_ARB_TMO_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        // A real result beats a watchdog expiry on the same edge.
        if (bus.i_eng_valid) begin
          state_d      = S_DONE;
          res_d        = bus.i_eng_res;
          vld_d[own_q] = 1'b1;
        end
`ifdef MMM_INV_ARB_TMO_EN
        else if (cnt_q == CW'(TMO_CYC - 1)) begin
          state_d      = S_DONE;
          res_d        = '0;
          err_d        = 1'b1;
          vld_d[own_q] = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      gnt_q   <= '0;
      vld_q   <= '0;
      eng_v_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      res_q   <= '0;
      n_q     <= '0;
      r_q     <= '0;
`ifdef MMM_INV_ARB_TMO_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      eng_v_q <= eng_v_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      res_q   <= res_d;
      n_q     <= n_d;
      r_q     <= r_d;
`ifdef MMM_INV_ARB_TMO_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.o_gnt       = gnt_q;
  assign bus.o_res       = res_q;
  assign bus.o_res_valid = vld_q;
  assign bus.o_err       = err_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_eng_n     = n_q;
  assign bus.o_eng_r     = r_q;
  assign bus.o_eng_valid = eng_v_q;
endmodule

// File: tb/tb_mmm_inv_arbiter.sv
// Directed-vector bench for mmm_inv_arbiter (NREQ=4, WIDTH=260, TMO_CYC=16).
module tb_mmm_inv_arbiter;
  localparam int W = 260;
  localparam int N = 4;

  logic i_clk = 1'b0;
  logic i_rstn;
  int   total = 0;
  int   bad   = 0;

  always #5 i_clk = ~i_clk;

  mmm_inv_arbiter_if #(.WIDTH(W), .NREQ(N)) bus ();

  mmm_inv_arbiter #(.WIDTH(W), .NREQ(N), .TMO_CYC(16)) dut (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .bus    (bus.slave)
  );

  function automatic logic [W-1:0] nv(input int k);
    logic [W-1:0] v;
    v = '0;
    v[W-1 -: 4] = 4'(k + 1);
    v[31:0]     = 32'hA000_0000 + 32'(k);
    return v;
  endfunction

  function automatic logic [W-1:0] rv(input int k);
    logic [W-1:0] v;
    v = '0;
    v[W-5 -: 4] = 4'(k + 9);
    v[31:0]     = 32'hB000_0000 + 32'(k);
    return v;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Entered in the grant cycle; leaves in the IDLE cycle after DONE.
  task automatic serve(input logic [N-1:0] g, input int lat, input logic [W-1:0] res);
    int k;
    k = 0;
    for (int i = 0; i < N; i++) if (g[i]) k = i;
    check("gnt", W'(bus.o_gnt), W'(g));
    check("eng_valid", W'(bus.o_eng_valid), W'(1));
    check("eng_n", bus.o_eng_n, nv(k));
    check("eng_r", bus.o_eng_r, rv(k));
    check("busy_issue", W'(bus.o_busy), W'(1));
    bus.i_req = bus.i_req & ~g;
    for (int i = 1; i <= lat; i++) begin
      tick();
      check("gnt_wait", W'(bus.o_gnt), '0);
      check("rv_wait", W'(bus.o_res_valid), '0);
      if (i == lat) begin
        bus.i_eng_valid = 1'b1;
        bus.i_eng_res   = res;
      end
    end
    tick();
    bus.i_eng_valid = 1'b0;
    check("res_valid", W'(bus.o_res_valid), W'(g));
    check("res", bus.o_res, res);
    check("err", W'(bus.o_err), '0);
    tick();
    check("busy_idle", W'(bus.o_busy), '0);
    check("rv_idle", W'(bus.o_res_valid), '0);
    check("res_hold", bus.o_res, res);
  endtask

  initial begin
    i_rstn          = 1'b0;
    bus.i_req       = '0;
    bus.i_eng_valid = 1'b0;
    bus.i_eng_res   = '0;
    for (int k = 0; k < N; k++) begin
      bus.i_n[k*W +: W] = nv(k);
      bus.i_r[k*W +: W] = rv(k);
    end
    tick();
    tick();
    check("rst_gnt", W'(bus.o_gnt), '0);
    check("rst_busy", W'(bus.o_busy), '0);
    check("rst_res", bus.o_res, '0);
    check("rst_eng_n", bus.o_eng_n, '0);
    check("rst_eng_valid", W'(bus.o_eng_valid), '0);
    i_rstn = 1'b1;
    tick();

    // Single request, L=5: grant at t+1, result valid at t+7.
    bus.i_req = 4'b0010;
    tick();
    serve(4'b0010, 5, W'(16'h1234));

    // Reset while in WAIT, then a late engine result must be dropped.
    bus.i_req = 4'b0100;
    tick();
    check("rw_gnt", W'(bus.o_gnt), W'(4'b0100));
    bus.i_req = '0;
    tick();
    tick();
    i_rstn = 1'b0;
    tick();
    i_rstn = 1'b1;
    check("rw_busy", W'(bus.o_busy), '0);
    check("rw_res", bus.o_res, '0);
    check("rw_eng_n", bus.o_eng_n, '0);
    check("rw_eng_r", bus.o_eng_r, '0);
    check("rw_rv", W'(bus.o_res_valid), '0);
    bus.i_eng_valid = 1'b1;
    bus.i_eng_res   = W'(16'hDEAD);
    tick();
    bus.i_eng_valid = 1'b0;
    check("rw_rv_late", W'(bus.o_res_valid), '0);
    check("rw_res_late", bus.o_res, '0);
    check("rw_busy_late", W'(bus.o_busy), '0);

    // All four requesting: ptr back at 0 so order is 0,1,2,3.
    bus.i_req = 4'b1111;
    tick();
    serve(4'b0001, 2, W'(16'h0A00));
    tick();
    serve(4'b0010, 3, W'(16'h0A11));
    tick();
    serve(4'b0100, 1, W'(16'h0A22));
    tick();
    serve(4'b1000, 4, W'(16'h0A33));
    tick();
    check("all_idle_gnt", W'(bus.o_gnt), '0);
    check("all_idle_busy", W'(bus.o_busy), '0);

    // Wrap: last grant was 3, so 1001 resolves to 0 then 3.
    bus.i_req = 4'b1001;
    tick();
    serve(4'b0001, 1, W'(16'h0B00));
    tick();
    serve(4'b1000, 2, W'(16'h0B33));

    // Stray engine valid in IDLE and ISSUE.
    bus.i_eng_valid = 1'b1;
    bus.i_eng_res   = W'(16'h0BAD);
    tick();
    bus.i_eng_valid = 1'b0;
    check("stray_idle_busy", W'(bus.o_busy), '0);
    check("stray_idle_rv", W'(bus.o_res_valid), '0);
    check("stray_idle_res", bus.o_res, W'(16'h0B33));
    bus.i_req = 4'b0010;
    tick();
    check("stray_gnt", W'(bus.o_gnt), W'(4'b0010));
    bus.i_req       = '0;
    bus.i_eng_valid = 1'b1;
    bus.i_eng_res   = W'(16'h0BAD);
    tick();
    bus.i_eng_valid = 1'b0;
    check("stray_issue_rv", W'(bus.o_res_valid), '0);
    check("stray_issue_busy", W'(bus.o_busy), W'(1));
    bus.i_eng_valid = 1'b1;
    bus.i_eng_res   = W'(16'h5555);
    tick();
    bus.i_eng_valid = 1'b0;
    check("stray_rv", W'(bus.o_res_valid), W'(4'b0010));
    check("stray_res", bus.o_res, W'(16'h5555));
    tick();

`ifdef MMM_INV_ARB_TMO_EN
    // Silent engine: DONE after 16 WAIT cycles with err set and zero result.
    bus.i_req = 4'b0100;
    tick();
    check("tmo_gnt", W'(bus.o_gnt), W'(4'b0100));
    bus.i_req = '0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("tmo_wait_rv", W'(bus.o_res_valid), '0);
    end
    tick();
    check("tmo_rv", W'(bus.o_res_valid), W'(4'b0100));
    check("tmo_err", W'(bus.o_err), W'(1));
    check("tmo_res", bus.o_res, '0);
    tick();
    check("tmo_idle", W'(bus.o_busy), '0);
    check("tmo_err_clr", W'(bus.o_err), '0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
